tetris_game_seq: RTL
====================

Name: tetris_game_seq

Overview:
- Central game sequencer for the 8x16 dot-matrix Tetris.
- Schedules every piece/map operation: spawn, gravity step, left/right shift, lock into map, full-row clear and game-over.
- Arbitrates the gravity tick and the debounced button pulses onto the single piece-update datapath, one operation per cycle.
- Sits between the second divider and debouncers (inputs) and the piece-position/map datapath (outputs). Drives the score shown on the two 7-segment digits.

Parameters:
- LOCK_DELAY, 2: gravity ticks a grounded piece survives before lock; legal range 1..7.
- SCORE_MAX, 99: score saturation value; fits two 7-seg digits.
- FAST_DIV, 4096: CLK cycles per soft-drop tick (SOFT_DROP_EN only).

Ports:
- CLK  in  1  system clock
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle gravity pulse
- move_left  in  1  debounced one-cycle pulse
- move_right  in  1  debounced one-cycle pulse
- collide_down  in  1  piece cannot move to y+1
- collide_left  in  1  piece cannot move to x-1
- collide_right  in  1  piece cannot move to x+1
- spawn_blocked  in  1  freshly spawned piece overlaps map; valid the cycle after spawn
- row_full  in  16  bit r = row r fully set; row 0 is the top
- spawn  out  1  pulse: load new piece at spawn position
- step_down  out  1  pulse: y += 1
- step_left  out  1  pulse: x -= 1
- step_right  out  1  pulse: x += 1
- lock  out  1  pulse: write piece into map
- clear_row  out  1  pulse: delete row clear_idx, shift rows above down
- clear_idx  out  4  row to clear
- score  out  7  rows cleared, saturating
- game_over  out  1  level
- state  out  3  current FSM state, for debug

Behaviour:
- Clock and reset: single clock CLK. `reset` is synchronous and active-high.
- Reset values: state=SPAWN, all pulses 0, clear_idx=0, score=0, game_over=0, lock counter=0, tick_pend=0.
- FSM states: SPAWN, CHECK, FALL, LOCK, SCAN, CLRWAIT, OVER.
- SPAWN:
  - Assert spawn for 1 cycle, then go to CHECK.
- CHECK:
  - spawn_blocked=1 -> OVER.
  - Otherwise -> FALL.
- FALL (at most one output pulse per cycle):
  - Priority: pending tick > move_left > move_right.
  - move_left and move_right in the same cycle: both ignored.
  - A tick arriving while a move is serviced sets tick_pend. tick_pend is serviced next cycle and cleared when serviced.
  - Tick with collide_down=0: step_down, lock counter := 0.
  - Tick with collide_down=1: lock counter += 1. If the counter reaches LOCK_DELAY -> LOCK.
  - Move with its collide flag=1: no pulse, move dropped. Moves remain legal while grounded.
  - Buttons arriving outside FALL are dropped. No queue.
- LOCK:
  - Assert lock for 1 cycle, counter := 0, then go to SCAN.
- SCAN:
  - row_full==0 -> SPAWN.
  - Otherwise: clear_idx := index of the lowest full row (highest index), assert clear_row, score := min(score+1, SCORE_MAX), then go to CLRWAIT.
- CLRWAIT:
  - One cycle for the map to shift, then return to SCAN. row_full is re-evaluated on fresh data.
  - A 4-row clear therefore takes 4 x 2 cycles + 1.
- OVER:
  - game_over=1, no pulses. Exited only by reset.
- Latency: every pulse is registered, one cycle after the causing input is sampled.
- Reset mid-operation: any state, including mid-clear, returns to the reset values on the next edge. The map itself is owned by the datapath.
- Ticks during SPAWN/CHECK/LOCK/SCAN/CLRWAIT: discarded; tick_pend cleared on entry to SPAWN.

Optional Feature:
- Macro: TETRIS_SOFT_DROP_EN.
- Defined:
  - Adds input `soft_drop` (1 bit, held level).
  - While soft_drop=1 in FALL, an internal counter generates a gravity tick every FAST_DIV cycles, OR-ed with `tick`.
  - The counter resets to 0 on soft_drop release and on SPAWN.
- Undefined: no port, no counter; gravity comes from `tick` only.

Decomposition:
- Shared package tetris_pkg holds:
  - state encoding constants (SPAWN=0 ... OVER=6),
  - MAP_W=8, MAP_H=16, SCORE_W=7,
  - the row index width.
- One natural sub-module: tetris_row_prio, a combinational priority encoder from 16-bit row_full to a 4-bit highest set index plus an any flag.

Test Plan:
- Reset: reset high 2 cycles -> spawn pulse one cycle after release; CHECK with spawn_blocked=0 -> state=FALL.
- Gravity and lock: collide_down=0, tick -> step_down next cycle. Then collide_down=1 with 2 ticks (LOCK_DELAY=2) -> lock pulse, then SCAN with row_full=0 -> spawn.
- Arbitration: tick, move_left, move_right in the same cycle -> step_down. Next cycle no move pulse (L+R cancel). A lone move_left with collide_left=1 -> no pulse.
- Tick during move: move_right then tick in the same cycle -> step_right, then step_down the cycle after.
- Multi-clear: row_full=0xC000, then 0x8000 after the first clear, then 0 -> clear_idx=15, score=1, then clear_idx=15, score=2, then spawn. With score preset to 99 -> stays 99.
- Game over: spawn_blocked=1 at CHECK -> game_over=1; ticks and buttons produce no pulses; reset -> score=0, spawn.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types and constants for the 8x16 dot-matrix Tetris sequencer.
// Optional soft drop is enabled with TETRIS_SOFT_DROP_EN.
package tetris_pkg;

    localparam int MAP_W   = 8;
    localparam int MAP_H   = 16;
    localparam int SCORE_W = 7;
    localparam int ROW_W   = $clog2(MAP_H);

    typedef enum logic [2:0] {
        SPAWN   = 3'd0,
        CHECK   = 3'd1,
        FALL    = 3'd2,
        LOCK    = 3'd3,
        SCAN    = 3'd4,
        CLRWAIT = 3'd5,
        OVER    = 3'd6
    } state_e;

endpackage

// File: rtl/tetris_row_prio.sv
// Priority encoder: index of the lowest full row (highest bit index).
// Row 0 is the top of the map, so a higher index is lower on screen.
module tetris_row_prio
    import tetris_pkg::*;
(
    input  logic [MAP_H-1:0] row_full,
    output logic [ROW_W-1:0] row_idx,
    output logic             row_any
);

    always_comb begin
        row_idx = '0;
        row_any = 1'b0;
        for (int i = 0; i < MAP_H; i++) begin
            if (row_full[i]) begin
                row_idx = ROW_W'(i);
                row_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tetris_game_seq.sv
// Central game sequencer: spawn, gravity, shifts, lock, row clear, game over.
// Define TETRIS_SOFT_DROP_EN to add the soft_drop input and fast gravity.
module tetris_game_seq
    import tetris_pkg::*;
#(
    parameter int LOCK_DELAY = 2,
    parameter int SCORE_MAX  = 99,
    parameter int FAST_DIV   = 4096
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               tick,
    input  logic               move_left,
    input  logic               move_right,
    input  logic               collide_down,
    input  logic               collide_left,
    input  logic               collide_right,
    input  logic               spawn_blocked,
    input  logic [MAP_H-1:0]   row_full,
`ifdef TETRIS_SOFT_DROP_EN
    input  logic               soft_drop,
`endif
    output logic               spawn,
    output logic               step_down,
    output logic               step_left,
    output logic               step_right,
    output logic               lock,
    output logic               clear_row,
    output logic [ROW_W-1:0]   clear_idx,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic [2:0]         state
);

    localparam logic [2:0]         LOCK_MAX = 3'(LOCK_DELAY);
    localparam logic [SCORE_W-1:0] SAT_MAX  = SCORE_W'(SCORE_MAX);

    state_e             state_q, state_d;
    logic               spawn_q, spawn_d;
    logic               step_down_q, step_down_d;
    logic               step_left_q, step_left_d;
    logic               step_right_q, step_right_d;
    logic               lock_q, lock_d;
    logic               clear_row_q, clear_row_d;
    logic [ROW_W-1:0]   clear_idx_q, clear_idx_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               game_over_q, game_over_d;
    logic [2:0]         lock_cnt_q, lock_cnt_d;
    logic               tick_pend_q, tick_pend_d;

    logic [ROW_W-1:0]   row_idx;
    logic               row_any;
    logic               grav_tick;
    logic               left_go;
    logic               right_go;
    logic               do_tick;
    logic [2:0]         lock_inc;

    tetris_row_prio u_row_prio (
        .row_full (row_full),
        .row_idx  (row_idx),
        .row_any  (row_any)
    );

`ifdef TETRIS_SOFT_DROP_EN
    localparam int DIV_W = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             fast_tick;

    assign fast_tick = soft_drop && (state_q == FALL) &&
                       (div_q == DIV_W'(FAST_DIV - 1));
    assign grav_tick = tick | fast_tick;

    always_comb begin
        div_d = div_q;
        if (!soft_drop || state_q == SPAWN) begin
            div_d = '0;
        end else if (state_q == FALL) begin
            div_d = fast_tick ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    assign grav_tick = tick;
`endif

    // Opposing buttons cancel; a blocked move is dropped and never
    // counts as servicing, so a same-cycle tick is taken directly.
    assign left_go  = move_left && !move_right && !collide_left;
    assign right_go = move_right && !move_left && !collide_right;
    assign lock_inc = lock_cnt_q + 3'd1;

    always_comb begin
        state_d      = state_q;
        spawn_d      = 1'b0;
        step_down_d  = 1'b0;
        step_left_d  = 1'b0;
        step_right_d = 1'b0;
        lock_d       = 1'b0;
        clear_row_d  = 1'b0;
        clear_idx_d  = clear_idx_q;
        score_d      = score_q;
        game_over_d  = game_over_q;
        lock_cnt_d   = lock_cnt_q;
        tick_pend_d  = tick_pend_q;
        do_tick      = 1'b0;

        unique case (state_q)
            SPAWN: begin
                spawn_d     = 1'b1;
                tick_pend_d = 1'b0;
                state_d     = CHECK;
            end
            CHECK: begin
                if (spawn_blocked) begin
                    state_d     = OVER;
                    game_over_d = 1'b1;
                end else begin
                    state_d = FALL;
                end
            end
            FALL: begin
                if (tick_pend_q) begin
                    do_tick     = 1'b1;
                    tick_pend_d = grav_tick;
                end else if (left_go || right_go) begin
                    step_left_d  = left_go;
                    step_right_d = right_go;
                    tick_pend_d  = grav_tick;
                end else if (grav_tick) begin
                    do_tick = 1'b1;
                end
                if (do_tick) begin
                    if (!collide_down) begin
                        step_down_d = 1'b1;
                        lock_cnt_d  = 3'd0;
                    end else begin
                        lock_cnt_d = lock_inc;
                        if (lock_inc >= LOCK_MAX) begin
                            state_d = LOCK;
                        end
                    end
                end
            end
            LOCK: begin
                lock_d     = 1'b1;
                lock_cnt_d = 3'd0;
                state_d    = SCAN;
            end
            SCAN: begin
                if (!row_any) begin
                    state_d = SPAWN;
                end else begin
                    clear_idx_d = row_idx;
                    clear_row_d = 1'b1;
                    if (score_q < SAT_MAX) begin
                        score_d = score_q + 1'b1;
                    end
                    state_d = CLRWAIT;
                end
            end
            CLRWAIT: begin
                state_d = SCAN;
            end
            OVER: begin
                game_over_d = 1'b1;
            end
            default: begin
                state_d = SPAWN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= SPAWN;
            spawn_q      <= 1'b0;
            step_down_q  <= 1'b0;
            step_left_q  <= 1'b0;
            step_right_q <= 1'b0;
            lock_q       <= 1'b0;
            clear_row_q  <= 1'b0;
            clear_idx_q  <= '0;
            score_q      <= '0;
            game_over_q  <= 1'b0;
            lock_cnt_q   <= 3'd0;
            tick_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            spawn_q      <= spawn_d;
            step_down_q  <= step_down_d;
            step_left_q  <= step_left_d;
            step_right_q <= step_right_d;
            lock_q       <= lock_d;
            clear_row_q  <= clear_row_d;
            clear_idx_q  <= clear_idx_d;
            score_q      <= score_d;
            game_over_q  <= game_over_d;
            lock_cnt_q   <= lock_cnt_d;
            tick_pend_q  <= tick_pend_d;
        end
    end

    assign spawn      = spawn_q;
    assign step_down  = step_down_q;
    assign step_left  = step_left_q;
    assign step_right = step_right_q;
    assign lock       = lock_q;
    assign clear_row  = clear_row_q;
    assign clear_idx  = clear_idx_q;
    assign score      = score_q;
    assign game_over  = game_over_q;
    assign state      = state_q;

endmodule
